cache_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single core-side port of the cache between a fetch-side master (port 0) and a load/store master (port 1). It accepts read or write requests from either port and issues exactly one one-cycle `core2cache_rd_en`/`core2cache_wr_en` pulse per transaction. It then waits for the matching `cache2core_*_fin` and returns a one-cycle done pulse, plus read data, to the granted port. It sits between the core pipeline and the cache controller, replacing any direct single-master connection.

---
 rtl/cache_port_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
// Two-master arbiter for the single core-side cache port; one transaction in flight.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin tie-break, otherwise port 0 has fixed priority.
module cache_port_arbiter #(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_rd_req,
   input  logic              m0_wr_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wr_data,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rd_data,
   input  logic              m1_rd_req,
   input  logic              m1_wr_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wr_data,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rd_data,
   output logic [ADDR_W-1:0] core2cache_rd_addr,
   output logic [ADDR_W-1:0] core2cache_wr_addr,
   output logic [DATA_W-1:0] core2cache_wr_data,
   output logic              core2cache_rd_en,
   output logic              core2cache_wr_en,
   input  logic              cache2core_rd_fin,
   input  logic              cache2core_wr_fin,
   input  logic [DATA_W-1:0] cache2core_rd_data,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic              req0;
   logic              req1;
   logic              pick1;
   logic              op_wr;
   logic              fin_hit;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;

   assign req0    = m0_rd_req | m0_wr_req;
   assign req1    = m1_rd_req | m1_wr_req;
   assign fin_hit = op_wr ? cache2core_wr_fin : cache2core_rd_fin;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // last1 remembers which port won the previous arbitration
   logic last1;

   assign pick1 = req1 & (~req0 | ~last1);

   always_ff @(posedge clk) begin
      if (rst)
         last1 <= 1'b1;
      else if (state == IDLE && (req0 || req1))
         last1 <= pick1;
   end
`else
   assign pick1 = req1 & ~req0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (req0 || req1) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (fin_hit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant      <= '0;
         op_wr      <= 1'b0;
         cur_addr   <= '0;
         cur_data   <= '0;
         m0_rd_data <= '0;
         m1_rd_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant    <= pick1 ? 2'b10 : 2'b01;
                  op_wr    <= pick1 ? m1_wr_req : m0_wr_req;
                  cur_addr <= pick1 ? m1_addr : m0_addr;
                  cur_data <= pick1 ? m1_wr_data : m0_wr_data;
               end
            end
            WAIT: begin
               if (cache2core_rd_fin && !op_wr) begin
                  if (grant[1])
                     m1_rd_data <= cache2core_rd_data;
                  else
                     m0_rd_data <= cache2core_rd_data;
               end
            end
            DONE:    grant <= '0;
            default: ;
         endcase
      end
   end

   assign core2cache_rd_addr = cur_addr;
   assign core2cache_wr_addr = cur_addr;
   assign core2cache_wr_data = cur_data;

   always_comb begin
      core2cache_rd_en = 1'b0;
      core2cache_wr_en = 1'b0;
      m0_done          = 1'b0;
      m1_done          = 1'b0;
      busy             = (state != IDLE);
      if (state == ISSUE) begin
         core2cache_rd_en = ~op_wr;
         core2cache_wr_en = op_wr;
      end
      if (state == DONE) begin
         m0_done = grant[0];
         m1_done = grant[1];
      end
   end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized transaction-level bench for cache_port_arbiter.
// Reference model predicts winner, op, address and read data per transaction.
module tb_cache_port_arbiter;
   localparam int AW = 27;
   localparam int DW = 32;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          rq_rd   [2];
   logic          rq_wr   [2];
   logic [AW-1:0] rq_addr [2];
   logic [DW-1:0] rq_wdata[2];
   logic          m0_done, m1_done;
   logic [DW-1:0] m0_rd_data, m1_rd_data;
   logic [AW-1:0] c_rd_addr, c_wr_addr;
   logic [DW-1:0] c_wr_data;
   logic          c_rd_en, c_wr_en;
   logic          rd_fin, wr_fin;
   logic [DW-1:0] fin_data;
   logic [1:0]    grant;
   logic          busy;

   int            n_chk = 0;
   int            n_pass = 0;
   int            last_win;
   logic [DW-1:0] mdl_rd[2];

   always #5 clk = ~clk;

   cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_rd_req(rq_rd[0]), .m0_wr_req(rq_wr[0]),
      .m0_addr(rq_addr[0]), .m0_wr_data(rq_wdata[0]),
      .m0_done(m0_done), .m0_rd_data(m0_rd_data),
      .m1_rd_req(rq_rd[1]), .m1_wr_req(rq_wr[1]),
      .m1_addr(rq_addr[1]), .m1_wr_data(rq_wdata[1]),
      .m1_done(m1_done), .m1_rd_data(m1_rd_data),
      .core2cache_rd_addr(c_rd_addr), .core2cache_wr_addr(c_wr_addr),
      .core2cache_wr_data(c_wr_data),
      .core2cache_rd_en(c_rd_en), .core2cache_wr_en(c_wr_en),
      .cache2core_rd_fin(rd_fin), .cache2core_wr_fin(wr_fin),
      .cache2core_rd_data(fin_data),
      .grant(grant), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_rd();
      check("m0_rd_data", m0_rd_data, mdl_rd[0]);
      check("m1_rd_data", m1_rd_data, mdl_rd[1]);
   endtask

   // one full transaction: predict, watch issue, return fin, watch done
   task automatic do_txn(input int dly, input bit wrong, input bit hold, input logic [DW-1:0] fdata);
      int            w;
      bit            wr, r0, r1;
      logic [1:0]    g;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      r0 = rq_rd[0] | rq_wr[0];
      r1 = rq_rd[1] | rq_wr[1];
      if (r0 && r1) w = (RR && last_win == 0) ? 1 : 0;
      else w = r0 ? 0 : 1;
      wr = rq_wr[w];
      g  = (w == 1) ? 2'b10 : 2'b01;
      ea = rq_addr[w];
      ed = rq_wdata[w];
      @(negedge clk);
      check("issue_rd_en", c_rd_en, !wr);
      check("issue_wr_en", c_wr_en, wr);
      check("issue_grant", grant, g);
      check("issue_rd_addr", c_rd_addr, ea);
      check("issue_wr_addr", c_wr_addr, ea);
      if (wr) check("issue_wr_data", c_wr_data, ed);
      check("issue_done", {m1_done, m0_done}, 2'b00);
      last_win = w;
      for (int i = 0; i <= dly; i++) begin
         @(negedge clk);
         check("wait_en", {c_rd_en, c_wr_en}, 2'b00);
         check("wait_done", {m1_done, m0_done}, 2'b00);
         check("wait_grant", grant, g);
         check("wait_addr", c_rd_addr, ea);
      end
      if (wrong) begin
         if (wr) rd_fin = 1'b1;
         else wr_fin = 1'b1;
         fin_data = DW'($urandom);
         @(negedge clk);
         rd_fin = 1'b0;
         wr_fin = 1'b0;
         check("wrong_fin_done", {m1_done, m0_done}, 2'b00);
         check("wrong_fin_busy", busy, 1'b1);
         check("wrong_fin_en", {c_rd_en, c_wr_en}, 2'b00);
      end
      if (wr) wr_fin = 1'b1;
      else rd_fin = 1'b1;
      fin_data = fdata;
      @(negedge clk);
      rd_fin   = 1'b0;
      wr_fin   = 1'b0;
      fin_data = DW'($urandom);
      if (!wr) mdl_rd[w] = fdata;
      check("done", {m1_done, m0_done}, g);
      check("done_grant", grant, g);
      check("done_busy", busy, 1'b1);
      check_rd();
      if (!hold) begin
         if (wr) rq_wr[w] = 1'b0;
         else rq_rd[w] = 1'b0;
      end
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_grant", grant, 2'b00);
      check("idle_done", {m1_done, m0_done}, 2'b00);
   endtask

   initial begin
      rst = 1'b1;
      rd_fin = 1'b0;
      wr_fin = 1'b0;
      fin_data = '0;
      for (int p = 0; p < 2; p++) begin
         rq_rd[p] = 1'b0;
         rq_wr[p] = 1'b0;
         rq_addr[p] = '0;
         rq_wdata[p] = '0;
         mdl_rd[p] = '0;
      end
      last_win = 1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_en", {c_rd_en, c_wr_en}, 2'b00);
      check("rst_done", {m1_done, m0_done}, 2'b00);
      check("rst_addr", {c_rd_addr, c_wr_addr}, '0);
      check("rst_wr_data", c_wr_data, '0);
      check_rd();
      @(negedge clk);
      check("idle_no_req", busy, 1'b0);

      rq_rd[0] = 1'b1;
      rq_addr[0] = 27'h0000010;
      do_txn(1, 1'b0, 1'b0, 32'hDEADBEEF);

      rq_wr[1] = 1'b1;
      rq_addr[1] = 27'h4000100;
      rq_wdata[1] = 32'h0000ffff;
      do_txn(0, 1'b0, 1'b0, 32'h12345678);

      rq_rd[0] = 1'b1;
      rq_addr[0] = 27'h0000200;
      rq_rd[1] = 1'b1;
      rq_addr[1] = 27'h0000300;
      for (int t = 0; t < 4; t++) do_txn(0, 1'b0, 1'b1, DW'($urandom));
      rq_rd[0] = 1'b0;
      rq_rd[1] = 1'b0;

      rq_rd[1] = 1'b1;
      rq_addr[1] = 27'h1234567;
      do_txn(1, 1'b1, 1'b0, 32'hCAFEF00D);

      rq_rd[0] = 1'b1;
      rq_wr[0] = 1'b1;
      rq_addr[0] = 27'h0ABCDEF;
      rq_wdata[0] = 32'hA5A5A5A5;
      do_txn(0, 1'b0, 1'b0, DW'($urandom));
      check("rd_left_after_wr", rq_rd[0], 1'b1);
      do_txn(2, 1'b0, 1'b0, 32'h0BADC0DE);

      rq_rd[0] = 1'b1;
      rq_addr[0] = 27'h0000040;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      rq_rd[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mdl_rd[0] = '0;
      mdl_rd[1] = '0;
      last_win = 1;
      check("rst_wait_grant", grant, 2'b00);
      check("rst_wait_busy", busy, 1'b0);
      check("rst_wait_en", {c_rd_en, c_wr_en}, 2'b00);
      check("rst_wait_done", {m1_done, m0_done}, 2'b00);
      check("rst_wait_addr", c_rd_addr, '0);
      check_rd();
      @(negedge clk);
      rd_fin = 1'b1;
      fin_data = 32'h55AA55AA;
      @(negedge clk);
      rd_fin = 1'b0;
      check("stale_fin_done", {m1_done, m0_done}, 2'b00);
      check("stale_fin_busy", busy, 1'b0);
      check_rd();
      @(negedge clk);
      check("stale_fin_done2", {m1_done, m0_done}, 2'b00);

      for (int t = 0; t < 40; t++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rq_rd[p] && !rq_wr[p] && $urandom_range(1, 0) == 1) begin
               rq_addr[p] = AW'($urandom);
               rq_wdata[p] = DW'($urandom);
               case ($urandom_range(2, 0))
                  0: rq_rd[p] = 1'b1;
                  1: rq_wr[p] = 1'b1;
                  default: begin
                     rq_rd[p] = 1'b1;
                     rq_wr[p] = 1'b1;
                  end
               endcase
            end
         end
         if (!rq_rd[0] && !rq_wr[0] && !rq_rd[1] && !rq_wr[1]) begin
            rq_addr[t % 2] = AW'($urandom);
            rq_rd[t % 2] = 1'b1;
         end
         do_txn($urandom_range(3, 0), $urandom_range(3, 0) == 0, 1'b0, DW'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
